// File: rtl/ram_queue_reader_pkg.sv
// Shared constants and small sizing helpers for the RAM-queue read side.
// No ports; imported by reg_fifo and ram_queue_reader.
package ram_queue_reader_pkg;

  // Read latency of the RAM queue port: data arrives one cycle after a fired read.
  localparam int Q_RD_LATENCY = 32'sd1;

  // Number of entries in the local holding buffer.
  function automatic int buf_depth(input int log2_buf);
    return 32'sd1 << log2_buf;
  endfunction

  // Width of an occupancy counter able to represent 0..buf_depth inclusive.
  function automatic int count_width(input int log2_buf);
    return log2_buf + 32'sd1;
  endfunction

endpackage

// File: rtl/ram_queue_reader_reg_fifo.sv
// reg_fifo: flop-based holding buffer, 2**LOG2_BUF entries of DATA_WIDTH bits.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   clr_i        synchronous clear of pointers and count (contents kept)
//   wr_en_i      write wr_data_i at the tail
//   wr_data_i    data to store
//   rd_en_i      advance the head (caller guarantees count_o != 0)
//   rd_data_o    entry at the head
//   count_o      occupancy, 0..2**LOG2_BUF
module reg_fifo
  import ram_queue_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LOG2_BUF   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [LOG2_BUF:0]     count_o
);

  localparam int DEPTH = buf_depth(LOG2_BUF);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2_BUF-1:0]   wr_ptr_q;
  logic [LOG2_BUF-1:0]   rd_ptr_q;
  logic [LOG2_BUF:0]     count_q;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + (LOG2_BUF)'(1);
      end
      if (rd_en_i) begin
        rd_ptr_q <= rd_ptr_q + (LOG2_BUF)'(1);
      end
      // Simultaneous write and read leaves the occupancy unchanged.
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + (LOG2_BUF + 1)'(1);
        2'b01:   count_q <= count_q - (LOG2_BUF + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/ram_queue_reader.sv
// ram_queue_reader: drains a RAM-backed queue (1-cycle read latency) into a
// registered valid/ready stream, issuing reads only when buffer space is
// guaranteed so no entry is lost or duplicated.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   q_empty_i    queue empty flag
//   q_rready_o   read request; a read fires when q_rready_o & ~q_empty_i
//   q_rdata_i    queue data, valid the cycle after a fired read
//   m_valid_o    downstream valid (buffer non-empty)
//   m_data_o     downstream data (buffer head)
//   m_ready_i    downstream accept
//   flush_i      drop buffered and in-flight entries
//   count_o      entries held in the buffer (in-flight excluded)
module ram_queue_reader
  import ram_queue_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LOG2_BUF   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  q_empty_i,
  output logic                  q_rready_o,
  input  logic [DATA_WIDTH-1:0] q_rdata_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  input  logic                  flush_i,
  output logic [LOG2_BUF:0]     count_o
);

  localparam int            CW      = count_width(LOG2_BUF);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(buf_depth(LOG2_BUF));

  logic              inflight_q;
  logic              inflight_d;
  logic              rst_q;
  logic              pop_s;
  logic              fire_s;
  logic              rready_s;
  logic [CW:0]       need_s;
  logic [CW-1:0]     count_s;

  assign m_valid_o  = (count_s != '0);
  assign pop_s      = m_valid_o & m_ready_i;
  assign fire_s     = rready_s & ~q_empty_i;
  assign inflight_d = fire_s & ~flush_i;
  assign q_rready_o = rready_s;
  assign count_o    = count_s;

  // Credit rule: request only if held + in-flight - leaving still leaves a free slot.
  always_comb begin
    need_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
    // rst_q keeps requests off for the first cycle after reset is released.
    if (reset | rst_q | flush_i) begin
      rready_s = 1'b0;
    end else begin
      rready_s = (need_s < DEPTH_W);
    end
  end

  // In-flight tracking and post-reset hold-off flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      rst_q      <= 1'b1;
    end else begin
      inflight_q <= inflight_d;
      rst_q      <= 1'b0;
    end
  end

  // Returning read data is captured only while a read is outstanding and no
  // flush is discarding it; pops are ignored for state during a flush.
  reg_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_BUF   (LOG2_BUF)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (flush_i),
    .wr_en_i   (inflight_q & ~flush_i),
    .wr_data_i (q_rdata_i),
    .rd_en_i   (pop_s & ~flush_i),
    .rd_data_o (m_data_o),
    .count_o   (count_s)
  );

endmodule

// File: tb/tb_ram_queue_reader.sv
module tb_ram_queue_reader;

  logic       clk;
  logic       reset;
  logic       q_empty_i;
  logic       q_rready_o;
  logic [3:0] q_rdata_i;
  logic       m_valid_o;
  logic [3:0] m_data_o;
  logic       m_ready_i;
  logic       flush_i;
  logic [1:0] count_o;

  ram_queue_reader #(.DATA_WIDTH(4), .LOG2_BUF(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .q_empty_i  (q_empty_i),
    .q_rready_o (q_rready_o),
    .q_rdata_i  (q_rdata_i),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_ready_i  (m_ready_i),
    .flush_i    (flush_i),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM queue model (4 entries) and reader reference model
  int rq[$];
  int ebuf[$];
  bit einfl;
  int einfl_d;
  bit erst;
  bit checking;
  int got[$];
  int got_cyc[$];
  int tests;
  int fails;

  // values seen at the last sample point
  logic       s_valid;
  logic       s_rready;
  logic [3:0] s_data;
  logic [1:0] s_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int v);
    rq.push_back(v);
    q_empty_i = 1'b0;
  endtask

  // One clock cycle: compare at negedge against the model, then advance the model.
  task automatic cycle(input bit do_push, input int pv);
    bit e_rdy, e_val, pop, fire;
    int e_cnt, rv;
    @(negedge clk);
    e_cnt = ebuf.size();
    e_val = (e_cnt != 0);
    pop   = e_val && m_ready_i;
    e_rdy = !reset && !erst && !flush_i && ((e_cnt + int'(einfl) - int'(pop)) < 2);
    fire  = e_rdy && (rq.size() != 0);
    if (checking) begin
      chk("q_rready", q_rready_o, e_rdy);
      chk("m_valid", m_valid_o, e_val);
      chk("count", count_o, e_cnt);
      if (e_val) chk("m_data", m_data_o, ebuf[0]);
    end
    s_valid  = m_valid_o;
    s_rready = q_rready_o;
    s_data   = m_data_o;
    s_count  = count_o;
    if (s_valid && m_ready_i) begin
      got.push_back(int'(s_data));
    end
    @(posedge clk);
    #1;
    rv = int'($urandom_range(0, 15));
    if (fire) rv = rq.pop_front();
    if (reset) begin
      ebuf.delete();
      einfl = 1'b0;
      erst  = 1'b1;
    end else begin
      erst = 1'b0;
      if (flush_i) begin
        ebuf.delete();
        einfl = 1'b0;
      end else begin
        if (pop) void'(ebuf.pop_front());
        if (einfl) ebuf.push_back(einfl_d);
        einfl   = fire;
        einfl_d = rv;
      end
    end
    q_rdata_i = 4'(rv);
    if (do_push) rq.push_back(pv);
    q_empty_i = (rq.size() == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; flush_i = 1'b0; m_ready_i = 1'b0; q_empty_i = 1'b1;
    q_rdata_i = 4'h5; einfl = 1'b0; einfl_d = 0; erst = 1'b1; checking = 1'b0;

    // 1: reset for 3 cycles, then release with empty queue
    cycle(1'b0, 0);
    checking = 1'b1;
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    reset = 1'b0;
    cycle(1'b0, 0);
    chk("t1_rready_c0", s_rready, 1'b0);
    cycle(1'b0, 0);
    chk("t1_rready_c1", s_rready, 1'b1);
    chk("t1_valid", s_valid, 1'b0);
    chk("t1_count", s_count, 2'd0);
    idle(3);

    // 2: single write, latency to output
    m_ready_i = 1'b1;
    cycle(1'b1, 3);                     // t=0
    cycle(1'b0, 0);                     // t=1: fires
    chk("t2_fire", (s_rready === 1'b1) && (rq.size() == 0), 1'b1);
    chk("t2_valid_t1", s_valid, 1'b0);
    cycle(1'b0, 0);                     // t=2
    chk("t2_valid_t2", s_valid, 1'b0);
    cycle(1'b0, 0);                     // t=3
    chk("t2_valid_t3", s_valid, 1'b1);
    chk("t2_data_t3", s_data, 4'h3);
    cycle(1'b0, 0);                     // t=4
    chk("t2_valid_t4", s_valid, 1'b0);
    idle(2);

    // 3: back-to-back stream
    got.delete();
    preload(1); preload(2); preload(3);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 0);
      if (s_valid) got_cyc.push_back(i);
    end
    chk("t3_len", got.size(), 3);
    if (got.size() == 3) begin
      chk("t3_seq", {got[0][3:0], got[1][3:0], got[2][3:0]}, 12'h123);
      chk("t3_gapless", got_cyc[2] - got_cyc[0], 2);
    end
    idle(2);

    // 4: back-pressure saturates the buffer
    m_ready_i = 1'b0;
    got.delete();
    preload(10); preload(11); preload(12);
    idle(10);
    chk("t4_count_sat", s_count, 2'd2);
    chk("t4_rready_off", s_rready, 1'b0);
    chk("t4_left_in_q", rq.size(), 1);
    m_ready_i = 1'b1;
    idle(8);
    chk("t4_len", got.size(), 3);
    if (got.size() == 3) chk("t4_seq", {got[0][3:0], got[1][3:0], got[2][3:0]}, 12'hABC);
    idle(2);

    // 5: flush with one held and one in flight
    m_ready_i = 1'b0;
    preload(5); preload(6); preload(7);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    flush_i = 1'b1;
    cycle(1'b0, 0);
    chk("t5_count_pre", s_count, 2'd1);
    flush_i = 1'b0;
    cycle(1'b0, 0);
    chk("t5_count_post", s_count, 2'd0);
    chk("t5_valid_post", s_valid, 1'b0);
    got.delete();
    m_ready_i = 1'b1;
    idle(6);
    chk("t5_len", got.size(), 1);
    if (got.size() == 1) chk("t5_next", got[0], 7);
    idle(2);

    // 6: reset mid-stream
    m_ready_i = 1'b0;
    preload(8); preload(9); preload(10); preload(11);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    reset = 1'b1;
    cycle(1'b0, 0);
    chk("t6_count_pre", s_count, 2'd1);
    reset = 1'b0;
    cycle(1'b0, 0);
    chk("t6_valid", s_valid, 1'b0);
    chk("t6_count", s_count, 2'd0);
    chk("t6_rready", s_rready, 1'b0);
    chk("t6_data", s_data, 4'h0);
    got.delete();
    m_ready_i = 1'b1;
    idle(8);
    chk("t6_len", got.size(), 2);
    if (got.size() == 2) chk("t6_seq", {got[0][3:0], got[1][3:0]}, 8'hAB);

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      flush_i   = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      cycle((rq.size() < 4) && ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)));
    end
    reset = 1'b0; flush_i = 1'b0; m_ready_i = 1'b1;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
